// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline definitions: datapath width, opcodes, hazard FSM states
package hazard_ctrl_pkg;

  localparam int BIN_DIG = 32;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  typedef enum logic [1:0] {HZ_RUN, HZ_FLUSH, HZ_STALL} hz_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - control/load-use hazard controller driving flush, redirect and stall
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int BIN_DIG      = hazard_ctrl_pkg::BIN_DIG,
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_STALL   = 2,
  parameter int CNT_W        = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ex_valid,
  input  logic [6:0]         ex_opcode,
  input  logic [4:0]         ex_rd,
  input  logic               ex_branch_taken,
  input  logic [BIN_DIG-1:0] ex_target,
  input  logic               de_valid,
  input  logic [4:0]         de_rs1,
  input  logic [4:0]         de_rs2,
  input  logic               de_use_rs1,
  input  logic               de_use_rs2,
  output logic               flush,
  output logic               redirect_valid,
  output logic [BIN_DIG-1:0] redirect_pc,
  output logic               stall,
  output logic [CNT_W-1:0]   flush_count,
  output logic [CNT_W-1:0]   stall_count
);

  hz_state_t          state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [BIN_DIG-1:0] target_q, target_d;

  logic ctl_hit, lu_hit, in_run, flush_take, stall_take;

  assign ctl_hit = ex_valid & ((ex_opcode == OP_JAL) | (ex_opcode == OP_JALR) |
                               ((ex_opcode == OP_BRANCH) & ex_branch_taken));
  assign lu_hit  = ex_valid & de_valid & (ex_opcode == OP_LOAD) & (ex_rd != 5'd0) &
                   ((de_use_rs1 & (de_rs1 == ex_rd)) | (de_use_rs2 & (de_rs2 == ex_rd)));

  // Control hazards win: a redirect squashes decode anyway, so stalling it is pointless.
  assign in_run     = (state_q == HZ_RUN);
  assign flush_take = in_run & ctl_hit;
  assign stall_take = in_run & lu_hit & ~ctl_hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      HZ_RUN: begin
        if (ctl_hit) begin
          state_d  = HZ_FLUSH;
          cnt_d    = 3'(FLUSH_CYCLES - 1);
          target_d = ex_target;
        end else if (lu_hit && (LOAD_STALL > 1)) begin
          state_d = HZ_STALL;
          cnt_d   = 3'(LOAD_STALL - 2);
        end
      end
      HZ_FLUSH, HZ_STALL: begin
        if (cnt_q == 3'd0) begin
          state_d = HZ_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= HZ_RUN;
      cnt_q    <= 3'd0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // The counter is loaded with FLUSH_CYCLES-1 on entry, so that value marks the first flush cycle.
  assign flush          = (state_q == HZ_FLUSH);
  assign redirect_valid = flush & (cnt_q == 3'(FLUSH_CYCLES - 1));
  assign redirect_pc    = target_q;
  assign stall          = (state_q == HZ_STALL) | stall_take;

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush_take),
    .count (flush_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_take),
    .count (stall_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int BD = 32;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ex_valid;
  logic [6:0]    ex_opcode;
  logic [4:0]    ex_rd;
  logic          ex_branch_taken;
  logic [BD-1:0] ex_target;
  logic          de_valid;
  logic [4:0]    de_rs1, de_rs2;
  logic          de_use_rs1, de_use_rs2;
  logic          flush, redirect_valid, stall;
  logic [BD-1:0] redirect_pc;
  logic [CW-1:0] flush_count, stall_count;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.BIN_DIG(BD), .FLUSH_CYCLES(2), .LOAD_STALL(2), .CNT_W(CW)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .ex_valid        (ex_valid),
    .ex_opcode       (ex_opcode),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_target       (ex_target),
    .de_valid        (de_valid),
    .de_rs1          (de_rs1),
    .de_rs2          (de_rs2),
    .de_use_rs1      (de_use_rs1),
    .de_use_rs2      (de_use_rs2),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .flush_count     (flush_count),
    .stall_count     (stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_opcode = 7'h13; ex_rd = 5'd0; ex_branch_taken = 1'b0;
    ex_target = '0; de_valid = 1'b0; de_rs1 = 5'd0; de_rs2 = 5'd0;
    de_use_rs1 = 1'b0; de_use_rs2 = 1'b0;
  endtask

  task automatic ex_op(input logic [6:0] op, input logic [4:0] rd, input logic tk,
                       input logic [31:0] tgt);
    ex_valid = 1'b1; ex_opcode = op; ex_rd = rd; ex_branch_taken = tk; ex_target = tgt;
  endtask

  task automatic de_use(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2);
    de_valid = 1'b1; de_rs1 = r1; de_use_rs1 = u1; de_rs2 = r2; de_use_rs2 = u2;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    tick(); tick();
    #1;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redir", 32'(redirect_valid), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fcnt", 32'(flush_count), 32'd0);
    chk("rst_scnt", 32'(stall_count), 32'd0);
    RST = 1'b0;

    // taken branch
    ex_op(7'h63, 5'd0, 1'b1, 32'h100); #1;
    chk("br_same_flush", 32'(flush), 32'd0);
    tick(); idle(); #1;
    chk("br_f1_flush", 32'(flush), 32'd1);
    chk("br_f1_redir", 32'(redirect_valid), 32'd1);
    chk("br_f1_rpc", redirect_pc, 32'h100);
    chk("br_f1_fcnt", 32'(flush_count), 32'd1);
    chk("br_f1_stall", 32'(stall), 32'd0);
    tick();
    chk("br_f2_flush", 32'(flush), 32'd1);
    chk("br_f2_redir", 32'(redirect_valid), 32'd0);
    chk("br_f2_rpc", redirect_pc, 32'h100);
    tick();
    chk("br_end_flush", 32'(flush), 32'd0);

    // not-taken branch
    ex_op(7'h63, 5'd0, 1'b0, 32'h200);
    tick(); idle(); #1;
    chk("nt_flush", 32'(flush), 32'd0);
    chk("nt_fcnt", 32'(flush_count), 32'd1);
    chk("nt_rpc", redirect_pc, 32'h100);

    // load-use via rs2
    ex_op(7'h03, 5'd5, 1'b0, 32'h0); de_use(5'd1, 1'b0, 5'd5, 1'b1); #1;
    chk("lu_c0_stall", 32'(stall), 32'd1);
    chk("lu_c0_flush", 32'(flush), 32'd0);
    tick(); idle(); #1;
    chk("lu_c1_stall", 32'(stall), 32'd1);
    chk("lu_c1_scnt", 32'(stall_count), 32'd1);
    tick();
    chk("lu_c2_stall", 32'(stall), 32'd0);

    // no hazard: rd=0, then rs2 not used
    ex_op(7'h03, 5'd0, 1'b0, 32'h0); de_use(5'd0, 1'b1, 5'd0, 1'b1); #1;
    chk("lu_rd0_stall", 32'(stall), 32'd0);
    tick();
    ex_op(7'h03, 5'd5, 1'b0, 32'h0); de_use(5'd1, 1'b1, 5'd5, 1'b0); #1;
    chk("lu_nouse_stall", 32'(stall), 32'd0);
    tick(); idle(); #1;
    chk("lu_none_stall", 32'(stall), 32'd0);
    chk("lu_none_scnt", 32'(stall_count), 32'd1);

    // load-use via rs1
    ex_op(7'h03, 5'd9, 1'b0, 32'h0); de_use(5'd9, 1'b1, 5'd2, 1'b1); #1;
    chk("lu_rs1_stall", 32'(stall), 32'd1);
    tick(); idle(); tick();
    chk("lu_rs1_scnt", 32'(stall_count), 32'd2);

    // JALR while decode reads ex_rd: flush only
    ex_op(7'h67, 5'd5, 1'b0, 32'h240); de_use(5'd5, 1'b1, 5'd5, 1'b1); #1;
    chk("jalr_c0_stall", 32'(stall), 32'd0);
    tick(); idle(); #1;
    chk("jalr_f1_flush", 32'(flush), 32'd1);
    chk("jalr_f1_rpc", redirect_pc, 32'h240);
    chk("jalr_f1_stall", 32'(stall), 32'd0);
    chk("jalr_fcnt", 32'(flush_count), 32'd2);
    chk("jalr_scnt", 32'(stall_count), 32'd2);
    // hazard inputs during FLUSH are ignored
    ex_op(7'h03, 5'd7, 1'b0, 32'h0); de_use(5'd7, 1'b1, 5'd0, 1'b0);
    tick();
    chk("jalr_f2_stall", 32'(stall), 32'd0);
    chk("jalr_f2_flush", 32'(flush), 32'd1);
    ex_op(7'h6F, 5'd1, 1'b0, 32'h777);
    tick(); idle();
    ex_op(7'h6F, 5'd1, 1'b0, 32'h300); #1;
    chk("b2b_run_flush", 32'(flush), 32'd0);
    chk("b2b_run_fcnt", 32'(flush_count), 32'd2);
    tick(); idle(); #1;
    chk("b2b_flush", 32'(flush), 32'd1);
    chk("b2b_redir", 32'(redirect_valid), 32'd1);
    chk("b2b_rpc", redirect_pc, 32'h300);
    chk("b2b_fcnt", 32'(flush_count), 32'd3);
    tick(); tick();

    // reset mid-FLUSH
    ex_op(7'h6F, 5'd1, 1'b0, 32'h400);
    tick(); idle(); tick();
    chk("rmf_f2_flush", 32'(flush), 32'd1);
    RST = 1'b1;
    tick(); RST = 1'b0; #1;
    chk("rmf_flush", 32'(flush), 32'd0);
    chk("rmf_redir", 32'(redirect_valid), 32'd0);
    chk("rmf_fcnt", 32'(flush_count), 32'd0);
    chk("rmf_rpc", redirect_pc, 32'd0);
    tick();
    chk("rmf_run_flush", 32'(flush), 32'd0);

    // saturation: 20 back-to-back JALs
    for (int i = 0; i < 20; i++) begin
      ex_op(7'h6F, 5'd1, 1'b0, 32'(i * 4));
      tick(); idle(); tick(); tick();
      if (i == 14) chk("sat_15", 32'(flush_count), 32'd15);
    end
    chk("sat_20", 32'(flush_count), 32'd15);
    chk("sat_scnt", 32'(stall_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
